// File: rtl/ifetch_unit_pkg.sv
// mips_pkg: shared fetch-stage types, widths and the misalignment helper
package mips_pkg;
  localparam int INSTR_W = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR = 32'h0;
  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_WAIT    = 2'd1,
    S_DISCARD = 2'd2
  } ifetch_state_t;
  function automatic logic is_misaligned(input logic [1:0] lsb);
    return lsb != 2'b00;
  endfunction
endpackage

// File: rtl/ifetch_unit_if.sv
// ifetch_unit_if: imem req/ack bus plus decode valid/ready bus; master = fetch unit, slave = memory and decode
interface ifetch_unit_if import mips_pkg::*; #(
  parameter int ADDR_W = 32
);
  logic               imem_req;
  logic [ADDR_W-1:0]  imem_addr;
  logic               imem_ack;
  logic [INSTR_W-1:0] imem_rdata;
  logic               if_valid;
  logic [INSTR_W-1:0] if_instr;
  logic [ADDR_W-1:0]  if_pc;
  logic               if_misalign;
  logic               id_ready;
  modport master (
    output imem_req, imem_addr, if_valid, if_instr, if_pc, if_misalign,
    input  imem_ack, imem_rdata, id_ready
  );
  modport slave (
    input  imem_req, imem_addr, if_valid, if_instr, if_pc, if_misalign,
    output imem_ack, imem_rdata, id_ready
  );
endinterface

// File: rtl/ifetch_unit_fetch_fifo.sv
// fetch_fifo: DEPTH x W FIFO with registered head (CLK/RSTn, push+din in, pop/clear in, head/valid/count out)
module fetch_fifo import mips_pkg::*; #(
  parameter int DEPTH = 2,
  parameter int W     = 65
) (
  input  logic                     CLK,
  input  logic                     RSTn,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     clear,
  input  logic [W-1:0]             din,
  output logic [W-1:0]             head,
  output logic                     valid,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else if (clear) begin
      wr_q  <= '0;
      rd_q  <= '0;
      count <= '0;
    end else begin
      if (push) mem_q[wr_q] <= din;
      wr_q  <= wr_q + AW'(push);
      rd_q  <= rd_q + AW'(pop);
      count <= count + (AW+1)'(push) - (AW+1)'(pop);
    end
  assign head  = mem_q[rd_q];
  assign valid = count != '0;
endmodule

// File: rtl/ifetch_unit.sv
// ifetch_unit: PC-driven fetch (CLK/RSTn, pc_in, pc_stall, flush; bus.master = imem req/ack + decode valid/ready)
module ifetch_unit import mips_pkg::*; #(
  parameter int DEPTH  = 2,
  parameter int ADDR_W = 32
) (
  input  logic              CLK,
  input  logic              RSTn,
  input  logic [ADDR_W-1:0] pc_in,
  output logic              pc_stall,
  input  logic              flush,
  ifetch_unit_if.master     bus
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int EW = ADDR_W + INSTR_W + 1;
  ifetch_state_t     state_q;
  logic              req_q;
  logic [ADDR_W-1:0] addr_q;
  logic [CW-1:0]     count;
  logic [EW-1:0]     head;
  logic              valid, issue, done, push;
  assign issue    = state_q == S_IDLE && !flush && count < CW'(DEPTH);
  assign done     = state_q != S_IDLE && bus.imem_ack;
  assign push     = state_q == S_WAIT && bus.imem_ack && !flush;
  assign pc_stall = !RSTn || !push;
  always_ff @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      state_q <= S_IDLE;
      req_q   <= 1'b0;
      addr_q  <= '0;
    end else begin
      state_q <= issue ? S_WAIT : done ? S_IDLE : state_q == S_WAIT && flush ? S_DISCARD : state_q;
      req_q   <= issue || (req_q && !done);
      if (issue) addr_q <= pc_in;
    end
  fetch_fifo #(.DEPTH(DEPTH), .W(EW)) u_fifo (
    .CLK   (CLK),
    .RSTn  (RSTn),
    .push  (push),
    .pop   (valid && bus.id_ready),
    .clear (flush),
    .din   ({addr_q, bus.imem_rdata, is_misaligned(addr_q[1:0])}),
    .head  (head),
    .valid (valid),
    .count (count)
  );
  assign bus.imem_req  = req_q;
  assign bus.imem_addr = addr_q;
  assign bus.if_valid  = valid;
  assign {bus.if_pc, bus.if_instr, bus.if_misalign} = head;
endmodule

// File: tb/tb_ifetch_unit.sv
// tb_ifetch_unit: scoreboard bench with PC-register and instruction-memory models around ifetch_unit
module tb_ifetch_unit;
  import mips_pkg::*;
  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        mis;
  } ent_t;
  logic        CLK = 1'b0;
  logic        RSTn = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] pc_in;
  logic        pc_stall;
  int          tests = 0;
  int          fails = 0;
  int          lat = 0;
  logic [31:0] redir_pc = 32'h0;
  ent_t        exp_q[$];
  logic        fl_q, adv_q, pop_q, drop, busy;
  ent_t        head_q;
  int          cnt;
  logic [31:0] exp_addr;
  ifetch_unit_if #(.ADDR_W(32)) bus();
  ifetch_unit #(.DEPTH(2), .ADDR_W(32)) dut (
    .CLK      (CLK),
    .RSTn     (RSTn),
    .pc_in    (pc_in),
    .pc_stall (pc_stall),
    .flush    (flush),
    .bus      (bus)
  );
  always #5 CLK = ~CLK;
  function automatic logic [31:0] instr_of(input logic [31:0] a);
    return ~a ^ 32'h5A5A_0000;
  endfunction
  always @(posedge CLK or negedge RSTn)
    if (!RSTn) begin
      fl_q   <= 1'b0;
      adv_q  <= 1'b0;
      pop_q  <= 1'b0;
      head_q <= '0;
    end else begin
      fl_q   <= flush;
      adv_q  <= ~pc_stall;
      pop_q  <= bus.if_valid && bus.id_ready;
      head_q <= {bus.if_pc, bus.if_instr, bus.if_misalign};
    end
  always @(negedge CLK or negedge RSTn)
    if (!RSTn) begin
      bus.imem_ack   = 1'b0;
      bus.imem_rdata = 32'h0;
      cnt = 0;
      drop = 1'b0;
      busy = 1'b0;
      exp_addr = 32'h0;
      pc_in = 32'h0;
      exp_q.delete();
    end else begin
      if (fl_q) begin
        exp_q.delete();
        pc_in = redir_pc;
        if (bus.imem_req) drop = 1'b1;
      end else begin
        if (pop_q) begin
          tests++;
          if (exp_q.size() == 0) begin
            fails++;
            $display("FAIL sb_pop: decode took pc=%h instr=%h, expected nothing", head_q.pc, head_q.instr);
          end else begin
            ent_t e;
            e = exp_q.pop_front();
            if (head_q !== e) begin
              fails++;
              $display("FAIL sb_pop: got pc=%h instr=%h mis=%b, want pc=%h instr=%h mis=%b",
                       head_q.pc, head_q.instr, head_q.mis, e.pc, e.instr, e.mis);
            end
          end
        end
        if (adv_q) pc_in = pc_in + 32'd4;
      end
      if (bus.imem_ack) bus.imem_ack = 1'b0;
      else if (bus.imem_req) begin
        if (!busy) begin
          busy = 1'b1;
          exp_addr = pc_in;
        end
        if (cnt == lat) begin
          bus.imem_ack   = 1'b1;
          bus.imem_rdata = instr_of(bus.imem_addr);
          if (!drop) exp_q.push_back({exp_addr, instr_of(exp_addr), exp_addr[1:0] != 2'b00});
          drop = 1'b0;
          busy = 1'b0;
          cnt = 0;
        end else cnt++;
      end
    end
  task automatic do_reset(input int l, input logic rdy, input logic [31:0] rp);
    @(posedge CLK);
    #2 RSTn = 1'b0;
    flush = 1'b0;
    lat = l;
    bus.id_ready = rdy;
    redir_pc = rp;
    repeat (2) @(negedge CLK);
    #1 RSTn = 1'b1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge CLK);
    #1;
    tests++; if (bus.imem_req !== 1'b0) begin fails++; $display("FAIL reset_req: got %b want 0", bus.imem_req); end
    tests++; if (bus.imem_addr !== 32'h0) begin fails++; $display("FAIL reset_addr: got %h want 0", bus.imem_addr); end
    tests++; if (bus.if_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", bus.if_valid); end
    tests++; if (bus.if_instr !== 32'h0) begin fails++; $display("FAIL reset_instr: got %h want 0", bus.if_instr); end
    tests++; if (bus.if_pc !== 32'h0) begin fails++; $display("FAIL reset_pc: got %h want 0", bus.if_pc); end
    tests++; if (bus.if_misalign !== 1'b0) begin fails++; $display("FAIL reset_mis: got %b want 0", bus.if_misalign); end
    tests++; if (pc_stall !== 1'b1) begin fails++; $display("FAIL reset_stall: got %b want 1", pc_stall); end
  endtask
  task automatic test_stream;
    lat = 0;
    bus.id_ready = 1'b1;
    @(negedge CLK);
    #1 RSTn = 1'b1;
    @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL stream_issue0: req=%b addr=%h valid=%b, want 1 0 0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    @(posedge CLK); #1;
    tests++; if ({bus.if_valid, bus.if_pc} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL stream_valid0: valid=%b pc=%h, want 1 0", bus.if_valid, bus.if_pc); end
    @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h4}) begin
      fails++; $display("FAIL stream_issue4: req=%b addr=%h, want 1 4", bus.imem_req, bus.imem_addr); end
    repeat (2) @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
      fails++; $display("FAIL stream_issue8: req=%b addr=%h, want 1 8", bus.imem_req, bus.imem_addr); end
    repeat (10) @(posedge CLK);
  endtask
  task automatic test_backpressure;
    int busy_cyc = 0;
    do_reset(0, 1'b0, 32'h0);
    for (int i = 0; i < 10; i++) begin
      @(posedge CLK); #1;
      if (i >= 5 && bus.imem_req) busy_cyc++;
    end
    tests++; if ({busy_cyc == 0, pc_stall, bus.if_valid, bus.if_pc} !== {1'b1, 1'b1, 1'b1, 32'h0}) begin
      fails++; $display("FAIL bp_full: req_cycles=%0d stall=%b valid=%b pc=%h, want 0 1 1 0", busy_cyc, pc_stall, bus.if_valid, bus.if_pc); end
    @(negedge CLK);
    bus.id_ready = 1'b1;
    for (int i = 0; i < 6 && !bus.imem_req; i++) begin @(posedge CLK); #1; end
    tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h8}) begin
      fails++; $display("FAIL bp_resume: req=%b addr=%h, want 1 8", bus.imem_req, bus.imem_addr); end
    repeat (6) @(posedge CLK);
  endtask
  task automatic test_latency;
    int ok = 0;
    do_reset(3, 1'b1, 32'h0);
    for (int i = 0; i < 4; i++) begin
      @(posedge CLK); #1;
      if ({bus.imem_req, bus.imem_addr, pc_stall} === {1'b1, 32'h0, 1'b1}) ok++;
    end
    tests++; if (ok != 4) begin fails++; $display("FAIL lat_hold: stable cycles %0d, want 4", ok); end
    @(negedge CLK); #1;
    tests++; if (pc_stall !== 1'b0) begin fails++; $display("FAIL lat_stall_ack: got %b want 0", pc_stall); end
    @(posedge CLK); #1;
    tests++; if ({bus.if_valid, bus.imem_req} !== 2'b10) begin
      fails++; $display("FAIL lat_push: valid=%b req=%b, want 1 0", bus.if_valid, bus.imem_req); end
    @(posedge CLK); #1;
    tests++; if ({bus.if_valid, bus.imem_req, bus.imem_addr} !== {1'b0, 1'b1, 32'h4}) begin
      fails++; $display("FAIL lat_single: valid=%b req=%b addr=%h, want 0 1 4", bus.if_valid, bus.imem_req, bus.imem_addr); end
    repeat (8) @(posedge CLK);
  endtask
  task automatic test_flush_wait;
    int vcnt = 0;
    do_reset(3, 1'b1, 32'h102);
    @(posedge CLK);
    @(negedge CLK);
    flush = 1'b1;
    @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h0, 1'b0}) begin
      fails++; $display("FAIL fw_hold: req=%b addr=%h valid=%b, want 1 0 0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    @(negedge CLK);
    flush = 1'b0;
    for (int i = 0; i < 8 && bus.imem_req; i++) begin @(posedge CLK); #1; if (bus.if_valid) vcnt++; end
    for (int i = 0; i < 8 && !bus.imem_req; i++) begin @(posedge CLK); #1; if (bus.if_valid) vcnt++; end
    tests++; if ({bus.imem_req, bus.imem_addr, vcnt == 0} !== {1'b1, 32'h102, 1'b1}) begin
      fails++; $display("FAIL fw_redirect: req=%b addr=%h stale_valid=%0d, want 1 102 0", bus.imem_req, bus.imem_addr, vcnt); end
    for (int i = 0; i < 8 && !bus.if_valid; i++) begin @(posedge CLK); #1; end
    tests++; if ({bus.if_valid, bus.if_pc, bus.if_misalign, bus.if_instr} !== {1'b1, 32'h102, 1'b1, instr_of(32'h102)}) begin
      fails++; $display("FAIL fw_misalign: valid=%b pc=%h mis=%b instr=%h, want 1 102 1 %h",
                        bus.if_valid, bus.if_pc, bus.if_misalign, bus.if_instr, instr_of(32'h102)); end
    repeat (4) @(posedge CLK);
  endtask
  task automatic test_flush_ack;
    do_reset(0, 1'b0, 32'h200);
    repeat (3) @(posedge CLK);
    @(negedge CLK);
    bus.id_ready = 1'b1;
    flush = 1'b1;
    @(posedge CLK); #1;
    tests++; if ({bus.if_valid, bus.imem_req, pc_stall} !== 3'b001) begin
      fails++; $display("FAIL fa_clear: valid=%b req=%b stall=%b, want 0 0 1", bus.if_valid, bus.imem_req, pc_stall); end
    @(negedge CLK);
    flush = 1'b0;
    @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr, bus.if_valid} !== {1'b1, 32'h200, 1'b0}) begin
      fails++; $display("FAIL fa_redirect: req=%b addr=%h valid=%b, want 1 200 0", bus.imem_req, bus.imem_addr, bus.if_valid); end
    repeat (6) @(posedge CLK);
  endtask
  task automatic test_async_reset;
    do_reset(3, 1'b0, 32'h0);
    repeat (6) @(posedge CLK);
    #1;
    tests++; if ({bus.if_valid, bus.imem_req, bus.imem_addr} !== {1'b1, 1'b1, 32'h4}) begin
      fails++; $display("FAIL ar_setup: valid=%b req=%b addr=%h, want 1 1 4", bus.if_valid, bus.imem_req, bus.imem_addr); end
    #1 RSTn = 1'b0;
    #1;
    tests++; if ({bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc, bus.if_misalign, pc_stall} !==
                 {1'b0, 32'h0, 1'b0, 32'h0, 32'h0, 1'b0, 1'b1}) begin
      fails++; $display("FAIL ar_values: req=%b addr=%h valid=%b instr=%h pc=%h mis=%b stall=%b, want 0 0 0 0 0 0 1",
                        bus.imem_req, bus.imem_addr, bus.if_valid, bus.if_instr, bus.if_pc, bus.if_misalign, pc_stall); end
    @(negedge CLK);
    bus.id_ready = 1'b1;
    lat = 0;
    #1 RSTn = 1'b1;
    @(posedge CLK); #1;
    tests++; if ({bus.imem_req, bus.imem_addr} !== {1'b1, 32'h0}) begin
      fails++; $display("FAIL ar_reissue: req=%b addr=%h, want 1 0", bus.imem_req, bus.imem_addr); end
    @(posedge CLK); #1;
    tests++; if ({bus.if_valid, bus.if_pc, bus.if_instr} !== {1'b1, 32'h0, instr_of(32'h0)}) begin
      fails++; $display("FAIL ar_first: valid=%b pc=%h instr=%h, want 1 0 %h", bus.if_valid, bus.if_pc, bus.if_instr, instr_of(32'h0)); end
    repeat (6) @(posedge CLK);
  endtask
  initial begin
    bus.id_ready = 1'b1;
    test_reset();
    test_stream();
    test_backpressure();
    test_latency();
    test_flush_wait();
    test_flush_ack();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
